i2s_codec_responder: RTL
========================

# i2s_codec_responder

- Codec-side end of the I2S link: follows externally driven BCLK/LRCLK, shifts parallel 24-bit samples out on ADC_SDATA and deserializes DAC_SDATA into parallel left/right words.
- Used as a synthesizable codec stand-in: AudioInterface and the voice-processing chain can run against it in loopback and in benches without the physical codec.
- Single clock domain; all link inputs are oversampled.

## Interface
Parameters:
- WIDTH, 24, sample bits per channel (MSB first)
- SLOT, 32, BCLK periods per channel slot; must be ≥ WIDTH+1

Ports:
- clk  in  1  system clock; must be ≥ 8× BCLK frequency
- reset  in  1  synchronous, active-high
- BCLK  in  1  bit clock from the link master
- LRCLK  in  1  word select from the link master; 0 = left, 1 = right
- DAC_SDATA  in  1  serial playback data from the master
- ADC_SDATA  out  1  serial record data to the master
- LeftTxData  in  WIDTH  left sample to send; sampled at TxLoad
- RightTxData  in  WIDTH  right sample to send; sampled at TxLoad
- TxLoad  out  1  one-clk pulse when both Tx words are latched
- LeftRxData  out  WIDTH  last complete left word received
- RightRxData  out  WIDTH  last complete right word received
- RxValid  out  1  one-clk pulse when a left/right pair completes
- error  out  1  sticky slot-length error

## Operation
- BCLK, LRCLK and DAC_SDATA each pass through a 2-flop synchronizer.
- A BCLK edge is detected by comparing the synchronized BCLK with a one-clk-delayed copy: rise = 0→1, fall = 1→0.
- Each rising edge samples lr = LRCLK_s and d = DAC_SDATA_s.
- Slot start: lr ≠ lr_prev. Then cnt ← 0 and synced ← 1.
- Otherwise cnt ← cnt+1, saturating at 63 (6-bit counter).
- Before synced = 1: no capture, no Tx load, ADC_SDATA = 0.
- Receive, on a rising edge with new cnt in 1..WIDTH:
  - rx_sr ← {rx_sr[WIDTH-2:0], d}.
  - cnt = 0 carries the LSB of the previous slot. It is discarded because it is padding.
- Word completion, when new cnt = WIDTH:
  - lr = 0: LeftRxData ← shifted value.
  - lr = 1: RightRxData ← shifted value, and RxValid pulses on the following clk.
- Transmit load:
  - On a slot start with lr = 0, hold_L ← LeftTxData and hold_R ← RightTxData.
  - TxLoad pulses one clk, on the clk after the detecting rise.
- Transmit drive, on each falling edge while synced:
  - cnt in 0..WIDTH-1: ADC_SDATA ← bit [WIDTH-1-cnt] of hold_L (lr = 0) or hold_R (lr = 1).
  - Otherwise ADC_SDATA ← 0.
  - Net effect: MSB appears one BCLK after the LRCLK transition (I2S delay).
- Error check, at a slot start with synced already 1:
  - If cnt+1 ≠ SLOT, error ← 1.
  - error clears only on reset.
  - The first slot after sync is never checked.
- Reset values:
  - ADC_SDATA, TxLoad, RxValid, error: 0.
  - LeftRxData, RightRxData, hold_L, hold_R, rx_sr: 0.
  - cnt = 0, synced = 0, lr_prev = 0, synchronizers = 0.
- Reset mid-frame: all state returns to reset values. Operation resumes at the next LRCLK transition seen on a BCLK rise. Any partial word is dropped.

## Timing
- Edge detection latency: 3 clk after a physical BCLK edge (2 sync + 1 compare).
- ADC_SDATA changes 4 clk after the physical falling edge, which leaves ≥ 0.5 BCLK − 4 clk of setup before the master's rising edge. This is why clk ≥ 8× BCLK is required.
- Rx word registers update 4 clk after the physical rise carrying the LSB. RxValid is high on the clk after that.
- TxLoad is high for exactly 1 clk per frame. The Tx inputs must be stable during that clk.
- Simultaneous events:
  - Slot start with cnt = WIDTH in the old slot: completion is handled on the earlier rise; there is no conflict.
  - A slot start with a short slot sets error, and the new slot still starts normally.
- LRCLK stuck (no transitions): cnt saturates at 63. No further captures or error after saturation. ADC_SDATA stays 0.

## Test plan
- Reset release, then LRCLK 1→0 → TxLoad is a single pulse at the first left slot; ADC_SDATA = 0 before it.
- LeftTxData = 24'hA5F00F, RightTxData = 24'h123456, BCLK = clk/16, SLOT = 32 → master-side capture on rising edges 1..24 of each slot reads A5F00F (left) and 123456 (right). Bits 0 and 25..31 read 0.
- DAC_SDATA driven with left 24'h800001 and right 24'h7FFFFF → RxValid pulses once per frame; LeftRxData = 800001 and RightRxData = 7FFFFF on that pulse.
- Change Tx inputs mid-frame → transmitted words change only after the next TxLoad; the current frame is unaffected.
- Third slot 31 BCLKs long → error = 1 at that slot end and remains 1; data capture continues correctly in later slots.
- Assert reset for 2 clk at bit 10 of a left slot → outputs return to 0. The first RxValid after reset comes one full frame after the next LRCLK transition, with correct data.

Source files
------------

// File: rtl/i2s_codec_responder.sv
// I2S codec-side responder: follows external BCLK/LRCLK,
// transmits held Tx words and deserializes DAC data.
module i2s_codec_responder #(
  parameter int WIDTH = 24,
  parameter int SLOT  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             BCLK,
  input  logic             LRCLK,
  input  logic             DAC_SDATA,
  output logic             ADC_SDATA,
  input  logic [WIDTH-1:0] LeftTxData,
  input  logic [WIDTH-1:0] RightTxData,
  output logic             TxLoad,
  output logic [WIDTH-1:0] LeftRxData,
  output logic [WIDTH-1:0] RightRxData,
  output logic             RxValid,
  output logic             error
);

  localparam int IW = $clog2(WIDTH);

  logic             r_bclk_s1, r_bclk_s2, r_bclk_d;
  logic             r_lr_s1, r_lr_s2;
  logic             r_d_s1, r_d_s2;
  logic             r_lr_prev;
  logic             r_synced;
  logic             r_have_left;
  logic [5:0]       r_cnt;
  logic [WIDTH-2:0] r_rx_sr;
  logic [WIDTH-1:0] r_hold_l, r_hold_r;
  logic [WIDTH-1:0] r_left_rx, r_right_rx;
  logic             r_adc;
  logic             r_txload;
  logic             r_rxvalid;
  logic             r_error;

  logic             w_rise, w_fall, w_start;
  logic [5:0]       w_cnt_nxt;
  logic             w_cap;
  logic [WIDTH-1:0] w_word;
  logic [6:0]       w_slot_len;
  logic [WIDTH-1:0] w_tx_word;
  logic [IW-1:0]    w_idx;
  logic             w_tx_bit;

  assign w_rise  = r_bclk_s2 & ~r_bclk_d;
  assign w_fall  = ~r_bclk_s2 & r_bclk_d;
  assign w_start = r_lr_s2 != r_lr_prev;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_start)
      w_cnt_nxt = 6'd0;
    else if (r_cnt != 6'd63)
      w_cnt_nxt = r_cnt + 6'd1;
  end

  // Count 0 holds the previous slot's LSB padding, so it never shifts in.
  assign w_cap = r_synced & ~w_start &
                 (w_cnt_nxt >= 6'd1) &
                 (w_cnt_nxt <= 6'(WIDTH));

  assign w_word     = {r_rx_sr, r_d_s2};
  assign w_slot_len = {1'b0, r_cnt} + 7'd1;

  assign w_tx_word = r_lr_prev ? r_hold_r : r_hold_l;
  assign w_idx     = IW'(WIDTH - 1 - int'(r_cnt));

  always_comb begin
    w_tx_bit = 1'b0;
    if (r_cnt < 6'(WIDTH))
      w_tx_bit = w_tx_word[w_idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bclk_s1   <= 1'b0;
      r_bclk_s2   <= 1'b0;
      r_bclk_d    <= 1'b0;
      r_lr_s1     <= 1'b0;
      r_lr_s2     <= 1'b0;
      r_d_s1      <= 1'b0;
      r_d_s2      <= 1'b0;
      r_lr_prev   <= 1'b0;
      r_synced    <= 1'b0;
      r_have_left <= 1'b0;
      r_cnt       <= 6'd0;
      r_rx_sr     <= '0;
      r_hold_l    <= '0;
      r_hold_r    <= '0;
      r_left_rx   <= '0;
      r_right_rx  <= '0;
      r_adc       <= 1'b0;
      r_txload    <= 1'b0;
      r_rxvalid   <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_bclk_s1 <= BCLK;
      r_bclk_s2 <= r_bclk_s1;
      r_bclk_d  <= r_bclk_s2;
      r_lr_s1   <= LRCLK;
      r_lr_s2   <= r_lr_s1;
      r_d_s1    <= DAC_SDATA;
      r_d_s2    <= r_d_s1;
      r_txload  <= 1'b0;
      r_rxvalid <= 1'b0;

      // Tx words are captured during the TxLoad cycle itself.
      if (r_txload) begin
        r_hold_l <= LeftTxData;
        r_hold_r <= RightTxData;
      end

      if (w_rise) begin
        r_lr_prev <= r_lr_s2;
        r_cnt     <= w_cnt_nxt;
        if (w_start) begin
          r_synced <= 1'b1;
          if (r_synced && (w_slot_len != 7'(SLOT)))
            r_error <= 1'b1;
          if (!r_lr_s2)
            r_txload <= 1'b1;
        end
        if (w_cap) begin
          r_rx_sr <= w_word[WIDTH-2:0];
          if (w_cnt_nxt == 6'(WIDTH)) begin
            if (r_lr_s2) begin
              r_right_rx <= w_word;
              if (r_have_left)
                r_rxvalid <= 1'b1;
            end else begin
              r_left_rx   <= w_word;
              r_have_left <= 1'b1;
            end
          end
        end
      end

      if (w_fall && r_synced)
        r_adc <= w_tx_bit;
    end
  end

  assign ADC_SDATA   = r_adc;
  assign TxLoad      = r_txload;
  assign RxValid     = r_rxvalid;
  assign error       = r_error;
  assign LeftRxData  = r_left_rx;
  assign RightRxData = r_right_rx;

endmodule
